// File: rtl/pos_step_ctrl.sv
// Frame-paced position stepper driving an external 8-bit up/down counter.
// Optional POS_STEP_ACCEL_EN: after 8 consecutive steps, step on every frame.
module pos_step_ctrl #(
    parameter logic [7:0] HOME        = 8'd76,
    parameter logic [7:0] LEFT_BOUND  = 8'd8,
    parameter logic [7:0] RIGHT_BOUND = 8'd144,
    parameter int         STEP_DIV    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       respawn,
    input  logic [7:0] Qin,
    output logic       UD,
    output logic       CE,
    output logic       LD,
    output logic [7:0] Din,
    output logic       at_left,
    output logic       at_right,
    output logic       moving
);

    typedef enum logic [1:0] {INIT, IDLE, MOVE} state_t;

    localparam logic [3:0] DIV   = 4'(STEP_DIV);
    localparam logic [3:0] ENTRY = 4'(STEP_DIV > 1);

    state_t     state_q, state_d;
    logic       ud_q, ud_d;
    logic       ce_q, ce_d;
    logic       ld_q, ld_d;
    logic       mv_q;
    logic [3:0] fcnt_q, fcnt_d, fcnt_inc;
    logic       frame_v, one_btn, due, blocked;
`ifdef POS_STEP_ACCEL_EN
    logic [2:0] run_q, run_d;
    logic       fast_q, fast_d;
`endif

    assign at_left  = (Qin <= LEFT_BOUND);
    assign at_right = (Qin >= RIGHT_BOUND);
    assign UD       = ud_q;
    assign CE       = ce_q;
    assign LD       = ld_q;
    assign moving   = mv_q;
    assign Din      = HOME;

    // A load cycle swallows any frame pulse that coincides with it
    assign frame_v  = frame & ~ld_q;
    assign one_btn  = btnL ^ btnR;
    assign fcnt_inc = fcnt_q + 4'd1;
    assign blocked  = ud_q ? at_right : at_left;
`ifdef POS_STEP_ACCEL_EN
    assign due      = (fcnt_inc == DIV) || fast_q;
`else
    assign due      = (fcnt_inc == DIV);
`endif

    always_comb begin
        state_d = state_q;
        ud_d    = ud_q;
        ce_d    = 1'b0;
        ld_d    = 1'b0;
        fcnt_d  = fcnt_q;
`ifdef POS_STEP_ACCEL_EN
        run_d   = run_q;
        fast_d  = fast_q;
`endif
        if (respawn) begin
            state_d = IDLE;
            ld_d    = 1'b1;
            fcnt_d  = 4'd0;
`ifdef POS_STEP_ACCEL_EN
            run_d   = 3'd0;
            fast_d  = 1'b0;
`endif
        end else begin
            unique case (state_q)
                INIT: begin
                    ld_d    = 1'b1;
                    state_d = IDLE;
                    fcnt_d  = 4'd0;
                end
                IDLE: begin
                    if (frame_v && one_btn) begin
                        state_d = MOVE;
                        ud_d    = btnR;
                        // The entry frame counts as the first frame of the run
                        fcnt_d  = ENTRY;
`ifdef POS_STEP_ACCEL_EN
                        run_d   = 3'd0;
                        fast_d  = 1'b0;
`endif
                    end
                end
                MOVE: begin
                    if (frame_v) begin
                        if (!one_btn || (btnR != ud_q)) begin
                            state_d = IDLE;
                            fcnt_d  = 4'd0;
`ifdef POS_STEP_ACCEL_EN
                            run_d   = 3'd0;
                            fast_d  = 1'b0;
`endif
                        end else if (due) begin
                            fcnt_d = 4'd0;
                            ce_d   = !blocked;
`ifdef POS_STEP_ACCEL_EN
                            if (!blocked) begin
                                if (run_q == 3'd7) fast_d = 1'b1;
                                else               run_d  = run_q + 3'd1;
                            end
`endif
                        end else begin
                            fcnt_d = fcnt_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            ud_q    <= 1'b0;
            ce_q    <= 1'b0;
            ld_q    <= 1'b0;
            mv_q    <= 1'b0;
            fcnt_q  <= 4'd0;
`ifdef POS_STEP_ACCEL_EN
            run_q   <= 3'd0;
            fast_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ud_q    <= ud_d;
            ce_q    <= ce_d;
            ld_q    <= ld_d;
            mv_q    <= (state_d == MOVE);
            fcnt_q  <= fcnt_d;
`ifdef POS_STEP_ACCEL_EN
            run_q   <= run_d;
            fast_q  <= fast_d;
`endif
        end
    end

endmodule

// File: tb/tb_pos_step_ctrl.sv
// Randomized bench for pos_step_ctrl against a frame-level behavioural model.
module tb_pos_step_ctrl;
    localparam logic [7:0] HOME = 8'd76;
    localparam logic [7:0] LB   = 8'd8;
    localparam logic [7:0] RB   = 8'd144;
    localparam int         DIV  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame = 1'b0, btnL = 1'b0, btnR = 1'b0, respawn = 1'b0;
    logic [7:0] qin = HOME;
    logic UD, CE, LD, at_left, at_right, moving;
    logic [7:0] Din;

    pos_step_ctrl #(.HOME(HOME), .LEFT_BOUND(LB), .RIGHT_BOUND(RB),
                    .STEP_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .frame(frame), .btnL(btnL), .btnR(btnR),
        .respawn(respawn), .Qin(qin), .UD(UD), .CE(CE), .LD(LD),
        .Din(Din), .at_left(at_left), .at_right(at_right), .moving(moving));

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, n_ce = 0;
    bit m_mv = 0, m_dir = 0;
    int m_fim = 0, m_iss = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame pulse (optionally with respawn) followed by model update and checks
    task automatic do_frame(input bit bl, input bit br, input bit rs);
        bit step, due;
        chk("at_left", at_left, qin <= LB);
        chk("at_right", at_right, qin >= RB);
        btnL = bl; btnR = br; frame = 1'b1; respawn = rs;
        @(negedge clk);
        frame = 1'b0; respawn = 1'b0;
        step = 0;
        if (rs) m_mv = 0;
        else if (!m_mv) begin
            if (bl ^ br) begin
                m_mv = 1; m_dir = br; m_fim = 1; m_iss = 0;
            end
        end else if (!(bl ^ br) || br != m_dir) m_mv = 0;
        else begin
            m_fim++;
            due = (m_fim % DIV) == 0;
`ifdef POS_STEP_ACCEL_EN
            if (m_iss >= 8) due = 1;
`endif
            if (due && (m_dir ? qin < RB : qin > LB)) begin
                step = 1; m_iss++;
            end
        end
        n_ce += int'(CE);
        chk("ce", CE, step);
        chk("ud", UD, m_dir);
        chk("moving", moving, m_mv);
        chk("ld", LD, rs);
        @(negedge clk);
        chk("ce_width", CE, 0);
        chk("ld_width", LD, 0);
        if (step) qin = m_dir ? qin + 8'd1 : qin - 8'd1;
        if (rs) qin = HOME;
    endtask

    task automatic do_reset_release();
        rst = 1'b0;
        m_mv = 0; m_dir = 0;
        @(negedge clk);
        chk("rel_ld", LD, 1);
        chk("rel_din", Din, HOME);
        chk("rel_ce", CE, 0);
        @(negedge clk);
        chk("rel_ld_off", LD, 0);
        chk("rel_moving", moving, 0);
        qin = HOME;
    endtask

    initial begin
        bit bl, br;
        repeat (3) @(negedge clk);
        chk("rst_ld", LD, 0);
        chk("rst_ce", CE, 0);
        chk("rst_ud", UD, 0);
        chk("rst_moving", moving, 0);
        do_reset_release();

        // btnR held 10 frames from HOME
        n_ce = 0;
        for (int i = 0; i < 10; i++) do_frame(0, 1, 0);
        chk("r_count", n_ce, 5);
        chk("r_pos", qin, HOME + 8'd5);

        // Blocked at the right bound, then reverse
        do_frame(0, 0, 1);
        qin = RB;
        n_ce = 0;
        for (int i = 0; i < 4; i++) do_frame(0, 1, 0);
        chk("rb_count", n_ce, 0);
        chk("rb_moving", moving, 1);
        chk("rb_at_right", at_right, 1);
        for (int i = 0; i < 5; i++) do_frame(1, 0, 0);
        chk("rb_back", qin, RB - 8'd2);

        // Respawn on a due step
        do_frame(0, 0, 1);
        do_frame(1, 0, 0);
        do_frame(1, 0, 1);
        do_frame(1, 0, 0);
        do_frame(1, 0, 0);

        // Both buttons
        n_ce = 0;
        for (int i = 0; i < 4; i++) do_frame(1, 1, 0);
        chk("both_count", n_ce, 0);
        chk("both_moving", moving, 0);

`ifdef POS_STEP_ACCEL_EN
        do_frame(0, 0, 1);
        qin = 8'd120;
        n_ce = 0;
        for (int i = 0; i < 30; i++) do_frame(1, 0, 0);
        chk("accel_count", n_ce, 22);
`endif

        // Randomized phase
        bl = 0; br = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bl = 1'($urandom);
            if ($urandom_range(0, 3) == 0) br = 1'($urandom);
            if ($urandom_range(0, 24) == 0) qin = 8'($urandom);
            do_frame(bl, br, $urandom_range(0, 19) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset mid-step aborts the pending CE
        do_frame(0, 0, 1);
        do_frame(0, 1, 0);
        btnR = 1'b1; frame = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        chk("abort_ce", CE, 0);
        chk("abort_moving", moving, 0);
        chk("abort_ld", LD, 0);
        btnR = 1'b0;
        do_reset_release();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
